mac_array: RTL and testbench

MAC_ARRAY -- requirements
Module: mac_array

---
 rtl/mac_array.sv | 150 +++++++++++++++
 tb/tb_mac_array.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array.sv
// -----------------------------------------------------------------------------
// mac_array
//   Four-lane multiply-accumulate array. A computation has four groups, and each
//   group has four valid beats. On every beat the shared input element x_in is
//   multiplied by one coefficient per lane (stage 1). The products are then
//   accumulated (stage 2). After the fourth beat of a group, each lane's dot
//   product is published on result1..4 and arithmetic_finish pulses. After the
//   fourth group, all_done pulses and the array returns to IDLE.
//
// Handshake: in_valid is a one-beat qualifier and needs no ready. A beat is
//   accepted on any rising edge where in_valid=1 and either the array is in RUN
//   or start is high in the same cycle. There is no back-pressure.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start               clear counters/accumulators and enter RUN
//   in_valid            qualifies x_in / coef_in
//   x_in [XW]           element shared by all lanes
//   coef_in [4*CW]      lane k coefficient at [CW*k +: CW]
//   result1..4 [RW]     lane 0..3 dot product of the last completed group
//   arithmetic_finish   one-cycle pulse when result1..4 update
//   group_idx [2]       group currently accumulating
//   busy                high while in RUN
//   all_done            one-cycle pulse alongside the group-3 finish
//   fsm_state           debug view of the FSM state (0=IDLE, 1=RUN)
// -----------------------------------------------------------------------------
module mac_array #(
  parameter int XW = 8,
  parameter int CW = 7,
  parameter int RW = 18
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            in_valid,
  input  logic [XW-1:0]   x_in,
  input  logic [4*CW-1:0] coef_in,
  output logic [RW-1:0]   result1,
  output logic [RW-1:0]   result2,
  output logic [RW-1:0]   result3,
  output logic [RW-1:0]   result4,
  output logic            arithmetic_finish,
  output logic [1:0]      group_idx,
  output logic            busy,
  output logic            all_done,
  output logic            fsm_state
);

  localparam int PW = XW + CW;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   prod_q [4];
  logic [RW-1:0]   acc_q  [4];
  logic [RW-1:0]   res_q  [4];
  logic            p_valid_q;
  logic [1:0]      beat_cnt_q;
  logic [1:0]      group_q;
  logic            finish_q;
  logic            all_done_q;

  logic            take_beat;
  logic            group_done;

  // A beat is accepted while running, or together with start as beat 0 of
  // the new computation.
  assign take_beat  = in_valid && (start || (state_q == RUN));

  // Completion of a group. start overrides it, so that edge produces no
  // finish pulse.
  assign group_done = (state_q == RUN) && p_valid_q && (beat_cnt_q == 2'd3) && !start;

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (!start && group_done && (group_q == 2'd3)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Stage 1: per-lane product register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_valid_q <= 1'b0;
      for (int k = 0; k < 4; k++) prod_q[k] <= '0;
    end else begin
      p_valid_q <= take_beat;
      if (take_beat) begin
        for (int k = 0; k < 4; k++)
          prod_q[k] <= PW'(x_in) * PW'(coef_in[CW*k +: CW]);
      end
    end
  end

  // Stage 2: accumulate, count beats, publish results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt_q <= '0;
      group_q    <= '0;
      finish_q   <= 1'b0;
      all_done_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        acc_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else begin
      finish_q   <= 1'b0;
      all_done_q <= 1'b0;
      if (start) begin
        // Discard any partial group. The published results stay untouched.
        beat_cnt_q <= '0;
        group_q    <= '0;
        for (int k = 0; k < 4; k++) acc_q[k] <= '0;
      end else if ((state_q == RUN) && p_valid_q) begin
        if (beat_cnt_q == 2'd3) begin
          beat_cnt_q <= '0;
          group_q    <= group_q + 2'd1;
          finish_q   <= 1'b1;
          all_done_q <= (group_q == 2'd3);
          for (int k = 0; k < 4; k++) begin
            res_q[k] <= acc_q[k] + RW'(prod_q[k]);
            acc_q[k] <= '0;
          end
        end else begin
          beat_cnt_q <= beat_cnt_q + 2'd1;
          for (int k = 0; k < 4; k++) acc_q[k] <= acc_q[k] + RW'(prod_q[k]);
        end
      end
    end
  end

  assign result1           = res_q[0];
  assign result2           = res_q[1];
  assign result3           = res_q[2];
  assign result4           = res_q[3];
  assign arithmetic_finish = finish_q;
  assign all_done          = all_done_q;
  assign group_idx         = group_q;
  assign busy              = (state_q == RUN);
  assign fsm_state         = state_q;

endmodule

// File: tb/tb_mac_array.sv
// -----------------------------------------------------------------------------
// tb_mac_array
//   Directed bench for mac_array. Inputs are driven and outputs are sampled
//   1 time unit after each rising edge. Each scenario task carries its own
//   hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_mac_array;

  localparam int XW = 8;
  localparam int CW = 7;
  localparam int RW = 18;

  localparam logic [27:0] ONES  = 28'h0204081;   // every lane coef = 1
  localparam logic [27:0] MAXC  = 28'hFFFFFFF;   // every lane coef = 127
  localparam logic [27:0] C1234 = {7'd4, 7'd3, 7'd2, 7'd1};

  logic            clk;
  logic            reset_n;
  logic            start;
  logic            in_valid;
  logic [XW-1:0]   x_in;
  logic [4*CW-1:0] coef_in;
  logic [RW-1:0]   result1, result2, result3, result4;
  logic            arithmetic_finish;
  logic [1:0]      group_idx;
  logic            busy;
  logic            all_done;
  logic            fsm_state;

  int checks;
  int failures;

  mac_array #(.XW(XW), .CW(CW), .RW(RW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .x_in(x_in), .coef_in(coef_in),
    .result1(result1), .result2(result2), .result3(result3), .result4(result4),
    .arithmetic_finish(arithmetic_finish), .group_idx(group_idx),
    .busy(busy), .all_done(all_done), .fsm_state(fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // driver: present one cycle of inputs, return 1 unit after the edge
  task automatic drive(input logic s, input logic v, input logic [XW-1:0] x,
                       input logic [4*CW-1:0] c);
    start = s; in_valid = v; x_in = x; coef_in = c;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 0; in_valid = 0; x_in = '0; coef_in = '0;
    #3;
    checks++;
    if ({arithmetic_finish, all_done, busy, group_idx} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {arithmetic_finish, all_done, busy, group_idx});
    end
    checks++;
    if ({result1, result2, result3, result4} !== '0) begin
      failures++; $display("FAIL reset_results got=%0d/%0d/%0d/%0d exp=0", result1, result2, result3, result4);
    end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    drive(1, 0, 0, ONES);
    checks++;
    if (busy !== 1'b1 || group_idx !== 2'd0) begin
      failures++; $display("FAIL basic_start busy=%b grp=%0d exp busy=1 grp=0", busy, group_idx);
    end
    for (int i = 1; i <= 4; i++) drive(0, 1, XW'(i), ONES);
    checks++;
    if (arithmetic_finish !== 1'b0) begin
      failures++; $display("FAIL basic_early_finish got=%b exp=0", arithmetic_finish);
    end
    drive(0, 0, 0, ONES);
    checks++;
    if (arithmetic_finish !== 1'b1 || all_done !== 1'b0 || group_idx !== 2'd1) begin
      failures++; $display("FAIL basic_finish fin=%b done=%b grp=%0d exp fin=1 done=0 grp=1", arithmetic_finish, all_done, group_idx);
    end
    checks++;
    if ({result1, result2, result3, result4} !== {4{18'd10}}) begin
      failures++; $display("FAIL basic_results got=%0d/%0d/%0d/%0d exp=10", result1, result2, result3, result4);
    end
    drive(0, 0, 0, ONES);
    checks++;
    if (arithmetic_finish !== 1'b0 || result3 !== 18'd10) begin
      failures++; $display("FAIL basic_hold fin=%b r3=%0d exp fin=0 r3=10", arithmetic_finish, result3);
    end
  endtask

  task automatic test_max;
    drive(1, 0, 0, MAXC);
    for (int i = 0; i < 4; i++) drive(0, 1, 8'd255, MAXC);
    drive(0, 0, 0, MAXC);
    checks++;
    if (arithmetic_finish !== 1'b1) begin
      failures++; $display("FAIL max_finish got=%b exp=1", arithmetic_finish);
    end
    checks++;
    if ({result1, result2, result3, result4} !== {4{18'd129540}}) begin
      failures++; $display("FAIL max_results got=%0d/%0d/%0d/%0d exp=129540", result1, result2, result3, result4);
    end
  endtask

  task automatic test_gaps;
    logic [RW-1:0] s;
    logic          saw;
    drive(1, 0, 0, C1234);
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 4; b++) begin
        drive(0, 1, XW'(g*4 + b + 1), C1234);
        checks++;
        if (arithmetic_finish !== 1'b0) begin
          failures++; $display("FAIL gaps_beat_fin g=%0d b=%0d got=1 exp=0", g, b);
        end
        drive(0, 0, 0, C1234);
        checks++;
        if (arithmetic_finish !== (b == 3)) begin
          failures++; $display("FAIL gaps_fin g=%0d b=%0d got=%b exp=%b", g, b, arithmetic_finish, (b == 3));
        end
        if (b == 3) begin
          s = RW'(16*g + 10);
          checks++;
          if ({result1, result2, result3, result4} !== {s, RW'(2*s), RW'(3*s), RW'(4*s)}) begin
            failures++; $display("FAIL gaps_results g=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", g,
                                 result1, result2, result3, result4, s, 2*s, 3*s, 4*s);
          end
          checks++;
          if (all_done !== (g == 3) || busy !== (g != 3) || group_idx !== 2'((g + 1) % 4)) begin
            failures++; $display("FAIL gaps_status g=%0d done=%b busy=%b grp=%0d exp done=%b busy=%b grp=%0d", g,
                                 all_done, busy, group_idx, (g == 3), (g != 3), (g + 1) % 4);
          end
        end
      end
    end
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 8'd9, C1234);
      saw |= arithmetic_finish;
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, C1234);
      saw |= arithmetic_finish;
    end
    checks++;
    if (saw !== 1'b0 || busy !== 1'b0 || result4 !== 18'd232) begin
      failures++; $display("FAIL gaps_idle_ignore fin_seen=%b busy=%b r4=%0d exp fin_seen=0 busy=0 r4=232", saw, busy, result4);
    end
  endtask

  task automatic test_back_to_back;
    drive(1, 0, 0, ONES);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, (i < 4) ? 8'd1 : 8'd2, ONES);
      checks++;
      if (arithmetic_finish !== (i == 4)) begin
        failures++; $display("FAIL b2b_fin i=%0d got=%b exp=%b", i, arithmetic_finish, (i == 4));
      end
      if (i == 4) begin
        checks++;
        if (result2 !== 18'd4 || group_idx !== 2'd1) begin
          failures++; $display("FAIL b2b_group0 r2=%0d grp=%0d exp r2=4 grp=1", result2, group_idx);
        end
      end
    end
    drive(0, 0, 0, ONES);
    checks++;
    if (arithmetic_finish !== 1'b1 || result1 !== 18'd8 || group_idx !== 2'd2 || busy !== 1'b1) begin
      failures++; $display("FAIL b2b_group1 fin=%b r1=%0d grp=%0d busy=%b exp fin=1 r1=8 grp=2 busy=1",
                           arithmetic_finish, result1, group_idx, busy);
    end
  endtask

  task automatic test_restart;
    logic saw;
    saw = 1'b0;
    drive(0, 1, 8'd9, ONES); saw |= arithmetic_finish;
    drive(0, 1, 8'd9, ONES); saw |= arithmetic_finish;
    drive(1, 0, 0, ONES);    saw |= arithmetic_finish;
    checks++;
    if (busy !== 1'b1 || group_idx !== 2'd0) begin
      failures++; $display("FAIL restart_state busy=%b grp=%0d exp busy=1 grp=0", busy, group_idx);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 8'd1, ONES); saw |= arithmetic_finish;
    end
    checks++;
    if (saw !== 1'b0) begin
      failures++; $display("FAIL restart_no_early_fin got=1 exp=0");
    end
    drive(0, 0, 0, ONES);
    checks++;
    if (arithmetic_finish !== 1'b1 || {result1, result2, result3, result4} !== {4{18'd4}}) begin
      failures++; $display("FAIL restart_results fin=%b r=%0d/%0d/%0d/%0d exp fin=1 r=4",
                           arithmetic_finish, result1, result2, result3, result4);
    end
    // start together with a valid beat: that beat is beat 0 of the new run
    drive(1, 1, 8'd5, ONES);
    checks++;
    if (group_idx !== 2'd0) begin
      failures++; $display("FAIL start_beat_grp got=%0d exp=0", group_idx);
    end
    for (int i = 0; i < 3; i++) drive(0, 1, 8'd1, ONES);
    drive(0, 0, 0, ONES);
    checks++;
    if (arithmetic_finish !== 1'b1 || result4 !== 18'd8 || group_idx !== 2'd1) begin
      failures++; $display("FAIL start_beat_result fin=%b r4=%0d grp=%0d exp fin=1 r4=8 grp=1",
                           arithmetic_finish, result4, group_idx);
    end
    // start on the edge that would have completed the group
    for (int i = 0; i < 4; i++) drive(0, 1, 8'd3, ONES);
    drive(1, 0, 0, ONES);
    checks++;
    if (arithmetic_finish !== 1'b0 || all_done !== 1'b0 || result1 !== 18'd8 || group_idx !== 2'd0 || busy !== 1'b1) begin
      failures++; $display("FAIL start_wins fin=%b done=%b r1=%0d grp=%0d busy=%b exp fin=0 done=0 r1=8 grp=0 busy=1",
                           arithmetic_finish, all_done, result1, group_idx, busy);
    end
    drive(0, 0, 0, ONES);
    checks++;
    if (arithmetic_finish !== 1'b0) begin
      failures++; $display("FAIL start_wins_late got=1 exp=0");
    end
  endtask

  task automatic test_reset_mid;
    logic saw;
    drive(1, 0, 0, ONES);
    for (int i = 0; i < 4; i++) drive(0, 1, 8'd2, ONES);
    drive(0, 1, 8'd7, ONES);
    drive(0, 1, 8'd7, ONES);
    checks++;
    if (result1 !== 18'd8 || group_idx !== 2'd1) begin
      failures++; $display("FAIL rstmid_pre r1=%0d grp=%0d exp r1=8 grp=1", result1, group_idx);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({result1, result2, result3, result4} !== '0 || busy !== 1'b0 || group_idx !== 2'd0 || arithmetic_finish !== 1'b0) begin
      failures++; $display("FAIL rstmid_async r1=%0d busy=%b grp=%0d fin=%b exp all 0",
                           result1, busy, group_idx, arithmetic_finish);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 8'd1, ONES); saw |= arithmetic_finish;
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, ONES); saw |= arithmetic_finish;
    end
    checks++;
    if (saw !== 1'b0 || busy !== 1'b0 || result1 !== '0) begin
      failures++; $display("FAIL rstmid_no_start fin_seen=%b busy=%b r1=%0d exp 0/0/0", saw, busy, result1);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_basic;
    test_max;
    test_gaps;
    test_back_to_back;
    test_restart;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
